psg_core: RTL and testbench

- Parametrised multi-channel programmable sound generator. Successor to the fixed two-tone signal_generator.
- Contains NUM_CH tone voices with full-width period writes, selectable pulse duty, per-voice tone/noise routing, one shared prescaled noise LFSR, a registered mixer and a glitch-free PWM DAC.
- Sits behind the same strobe/address/data register bus and drives the single audio pin.

---
 rtl/psg_pkg.sv | 37 +++
 rtl/psg_if.sv | 11 +
 rtl/psg_voice.sv | 66 ++++++
 rtl/psg_core.sv | 121 ++++++++++++
 tb/tb_psg_core.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/psg_pkg.sv
// Shared constants, register offsets and types for the programmable sound generator.
package psg_pkg;

  localparam logic [1:0] REG_PLO     = 2'd0;
  localparam logic [1:0] REG_PHI     = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;

  localparam logic [1:0] GREG_NOISE  = 2'd0;
  localparam logic [1:0] GREG_MASTER = 2'd1;
  localparam logic [1:0] GREG_RETRIG = 2'd2;

  typedef enum logic [1:0] {
    DUTY_50 = 2'b00,
    DUTY_25 = 2'b01,
    DUTY_12 = 2'b10,
    DUTY_75 = 2'b11
  } duty_e;

  // Field order mirrors the ctrl register byte, so a data byte casts straight in.
  typedef struct packed {
    duty_e      duty;
    logic       noiseEn;
    logic       toneEn;
    logic [3:0] vol;
  } voice_ctrl_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/psg_if.sv
// Strobe/address/data register write bus shared by the sound generator family.
interface psg_if #(
  parameter int ADDR_W = 4
);
  logic              write_strobe;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data;

  modport master (output write_strobe, address, data);
  modport slave  (input  write_strobe, address, data);
endinterface

// File: rtl/psg_voice.sv
// One tone voice: period register with low-byte shadow, reload counter, 3-bit phase, duty decode.
module psg_voice
  import psg_pkg::*;
#(
  parameter int PERIOD_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrLo,
  input  logic       wrHi,
  input  logic       retrig,
  input  logic [7:0] wrData,
  input  duty_e      duty,
  output logic       wave
);

  logic [7:0]          shadowLo;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] counter;
  logic [2:0]          phase;
  logic                pulse;

  // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadowLo <= '0;
      period   <= '0;
    end else begin
      if (wrLo) shadowLo <= wrData;
      if (wrHi) period   <= {wrData[PERIOD_W-9:0], shadowLo};
    end
  end

  // A new period is only picked up on reload, so a running count is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      phase   <= '0;
    end else if (retrig) begin
      counter <= period;
      phase   <= '0;
    end else if (period != '0) begin
      if (counter == '0) begin
        counter <= period;
        phase   <= phase + 3'd1;
      end else begin
        counter <= counter - PERIOD_W'(1);
      end
    end
  end

  // NOTE: pulse gets a default first so no path through the case leaves it unassigned.
  always_comb begin
    pulse = 1'b0;
    case (duty)
      DUTY_50: pulse = (phase < 3'd4);
      DUTY_25: pulse = (phase < 3'd2);
      DUTY_12: pulse = (phase == 3'd0);
      DUTY_75: pulse = (phase < 3'd6);
      default: pulse = 1'b0;
    endcase
  end

  assign wave = pulse && (period != '0);

endmodule

// File: rtl/psg_core.sv
// Multi-voice sound generator: register decode, voices, shared noise LFSR, mixer and PWM DAC.
module psg_core
  import psg_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4,
  parameter int PWM_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  psg_if.slave              bus,
  output logic              signal_out,
  output logic [PWM_W-1:0]  mix_level,
  output logic [NUM_CH-1:0] wave_o,
  output logic              noise_o
);

  localparam int CH_AW = clog2(NUM_CH + 1);
  localparam int SUM_W = VOL_W + clog2(NUM_CH);

  logic [CH_AW-1:0]  bank;
  logic [1:0]        regSel;
  logic              globalWr;
  logic [NUM_CH-1:0] retrigMask;

  voice_ctrl_t       ctrl [NUM_CH];
  logic [7:0]        noisePeriod;
  logic              masterEn;

  logic [7:0]        prescale;
  logic [15:0]       lfsr;
  logic [15:0]       lfsrNext;

  logic [SUM_W-1:0]  sum;
  logic [PWM_W-1:0]  pwmCnt;
  logic [PWM_W-1:0]  dutyLatched;

  assign bank       = bus.address[CH_AW+1:2];
  assign regSel     = bus.address[1:0];
  assign globalWr   = bus.write_strobe && (bank == CH_AW'(NUM_CH));
  assign retrigMask = (globalWr && regSel == GREG_RETRIG) ? bus.data[NUM_CH-1:0] : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
    logic sel;
    assign sel = bus.write_strobe && (bank == CH_AW'(i));

    psg_voice #(
      .PERIOD_W (PERIOD_W)
    ) u_voice (
      .clk    (clk),
      .rst    (rst),
      .wrLo   (sel && regSel == REG_PLO),
      .wrHi   (sel && regSel == REG_PHI),
      .retrig (retrigMask[i]),
      .wrData (bus.data),
      .duty   (ctrl[i].duty),
      .wave   (wave_o[i])
    );
  end

  // NOTE: ctrl is a few flops per voice, not a RAM, so it resets with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) ctrl[i] <= '0;
      noisePeriod <= 8'hFF;
      masterEn    <= 1'b1;
    end else if (bus.write_strobe) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bank == CH_AW'(i) && regSel == REG_CTRL) ctrl[i] <= voice_ctrl_t'(bus.data);
      end
      if (bank == CH_AW'(NUM_CH)) begin
        if (regSel == GREG_NOISE)  noisePeriod <= bus.data;
        if (regSel == GREG_MASTER) masterEn    <= bus.data[0];
      end
    end
  end

  assign lfsrNext = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  assign noise_o  = lfsr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      lfsr     <= LFSR_SEED;
    end else if (prescale == '0) begin
      prescale <= noisePeriod;
      lfsr     <= lfsrNext;
    end else begin
      prescale <= prescale - 8'd1;
    end
  end

  // A voice with both sources off is silent even though its gate would read 1.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((ctrl[i].toneEn || ctrl[i].noiseEn) &&
          (ctrl[i].toneEn  ? wave_o[i] : 1'b1) &&
          (ctrl[i].noiseEn ? noise_o   : 1'b1)) begin
        sum = sum + SUM_W'(VOL_W'(ctrl[i].vol));
      end
    end
  end

  // Duty only changes at the end of a PWM period, so the pin never sees a torn period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_level   <= '0;
      pwmCnt      <= '0;
      dutyLatched <= '0;
      signal_out  <= 1'b0;
    end else begin
      mix_level  <= masterEn ? (PWM_W'(sum) << (PWM_W - SUM_W)) : '0;
      pwmCnt     <= pwmCnt + PWM_W'(1);
      if (&pwmCnt) dutyLatched <= mix_level;
      signal_out <= (pwmCnt < dutyLatched);
    end
  end

endmodule

// File: tb/tb_psg_core.sv
// Directed bench for psg_core: reset, noise sequence, duty, period commit, mixing, decode and PWM.
module tb_psg_core;
  import psg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       signal_out;
  logic [7:0] mix_level;
  logic [2:0] wave_o;
  logic       noise_o;

  int nChecks = 0;
  int nPass   = 0;
  int cyc;

  psg_if #(.ADDR_W(4)) busIf ();

  psg_core #(
    .NUM_CH   (3),
    .PERIOD_W (12),
    .VOL_W    (4),
    .PWM_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (busIf),
    .signal_out (signal_out),
    .mix_level  (mix_level),
    .wave_o     (wave_o),
    .noise_o    (noise_o)
  );

  always #5 clk = ~clk;

  // Posedges seen since reset release; equals the DUT PWM counter modulo 256.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic driveBus(input logic [1:0] bank, input logic [1:0] regSel, input logic [7:0] val);
    busIf.write_strobe = 1'b1;
    busIf.address      = {bank, regSel};
    busIf.data         = val;
  endtask

  // Lands a write on posedge number edgeNo and returns at the negedge right after it.
  task automatic wrAt(input int edgeNo, input logic [1:0] bank, input logic [1:0] regSel,
                      input logic [7:0] val);
    if (cyc > edgeNo - 1) check("wr_schedule", cyc, edgeNo - 1);
    while (cyc < edgeNo - 1) @(negedge clk);
    driveBus(bank, regSel, val);
    @(negedge clk);
    busIf.write_strobe = 1'b0;
  endtask

  task automatic wr(input logic [1:0] bank, input logic [1:0] regSel, input logic [7:0] val);
    wrAt(cyc + 1, bank, regSel, val);
  endtask

  task automatic waitTo(input int edgeNo);
    while (cyc < edgeNo) @(negedge clk);
  endtask

  task automatic countWave(input int n, input int ch, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      if (wave_o[ch] === 1'b1) hits++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", nPass, nChecks);
    $fatal(1);
  end

  initial begin
    logic [15:0] expLfsr;
    int quietBad, noiseBad, hits, waveHits, sigHits, peak;
    int r, r2, r3;

    busIf.write_strobe = 1'b0;
    busIf.address      = '0;
    busIf.data         = '0;

    // Reset state
    #12;
    check("rst_signal", signal_out, 0);
    check("rst_mix",    mix_level,  0);
    check("rst_wave",   wave_o,     0);
    check("rst_noise",  noise_o,    1);   // bit 0 of 16'hACE1
    @(negedge clk);
    rst = 1'b0;

    // Idle output for 1000 cycles; noise steps every 256, then every cycle once period 0 reloads
    expLfsr  = 16'hACE1;
    quietBad = 0;
    noiseBad = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      busIf.write_strobe = 1'b0;
      if (k >= 1025 || ((k - 1) % 256) == 0) expLfsr = lfsrStep(expLfsr);
      if (noise_o !== expLfsr[0]) noiseBad++;
      if (k <= 1000 && (signal_out !== 1'b0 || mix_level !== 8'd0 || wave_o !== 3'd0)) quietBad++;
      if (k == 1000) driveBus(2'd3, GREG_NOISE, 8'h00);
    end
    check("idle_quiet", quietBad, 0);
    check("noise_seq",  noiseBad, 0);

    // Voice 0: period 3, vol 8, tone, duty 50; retrigger lands at 248 mod 256
    wr(2'd0, REG_PLO, 8'h03);
    wr(2'd0, REG_PHI, 8'h00);
    wr(2'd0, REG_CTRL, 8'h18);
    r = 1272;
    wrAt(r, 2'd3, GREG_RETRIG, 8'h01);
    waveHits = 0;
    sigHits  = 0;
    for (int k = r; k <= 1536; k++) begin
      if (k < r + 64 && wave_o[0] === 1'b1) waveHits++;
      if (k >= 1281 && signal_out === 1'b1) sigHits++;
      if (k == r)      check("v0_wave_start", wave_o[0], 1);
      if (k == r + 15) check("v0_wave_hi_end", wave_o[0], 1);
      if (k == r + 16) check("v0_wave_lo", wave_o[0], 0);
      if (k == r + 32) check("v0_wave_period", wave_o[0], 1);
      if (k == r + 16) check("v0_mix_hi", mix_level, 32);
      if (k == r + 17) check("v0_mix_lo", mix_level, 0);
      if (k == 1281)   check("pwm_first_hi", signal_out, 1);
      if (k == 1313)   check("pwm_first_lo", signal_out, 0);
      @(negedge clk);
    end
    check("v0_wave_hits_64", waveHits, 32);
    check("pwm_hits_256", sigHits, 32);

    // Duty variants at period 3
    wr(2'd0, REG_CTRL, 8'h98);
    countWave(32, 0, hits);
    check("duty_12_hits", hits, 4);
    wr(2'd0, REG_CTRL, 8'hD8);
    countWave(32, 0, hits);
    check("duty_75_hits", hits, 24);
    wr(2'd0, REG_CTRL, 8'h58);
    countWave(32, 0, hits);
    check("duty_25_hits", hits, 8);

    // Low byte alone must not disturb the running period
    wr(2'd0, REG_CTRL, 8'h18);
    wr(2'd0, REG_PLO, 8'h10);
    countWave(64, 0, hits);
    check("plo_only_hits", hits, 32);

    // Commit period 16 two cycles after a retrigger: old count finishes, then 17-cycle phases
    r2 = cyc + 4;
    wrAt(r2, 2'd3, GREG_RETRIG, 8'h01);
    wrAt(r2 + 2, 2'd0, REG_PHI, 8'h00);
    waitTo(r2 + 4);   check("commit_ph1", wave_o[0], 1);
    waitTo(r2 + 54);  check("commit_ph3_end", wave_o[0], 1);
    waitTo(r2 + 55);  check("commit_ph4", wave_o[0], 0);
    waitTo(r2 + 122); check("commit_ph7_end", wave_o[0], 0);
    waitTo(r2 + 123); check("commit_wrap", wave_o[0], 1);

    // Three voices at full volume, aligned by one retrigger
    for (int v = 0; v < 3; v++) begin
      wr(2'(v), REG_PLO, 8'h03);
      wr(2'(v), REG_PHI, 8'h00);
      wr(2'(v), REG_CTRL, 8'h1F);
    end
    r3 = cyc + 3;
    wrAt(r3, 2'd3, GREG_RETRIG, 8'h07);
    check("retrig_aligned", wave_o, 3'b111);
    waitTo(r3 + 1); check("mix_peak_180", mix_level, 180);
    wrAt(r3 + 3, 2'd3, GREG_MASTER, 8'h00);
    waitTo(r3 + 4); check("master_off_mix", mix_level, 0);
    check("master_off_wave", wave_o, 3'b111);
    wrAt(r3 + 6, 2'd3, GREG_MASTER, 8'h01);
    peak = 0;
    for (int k = r3 + 8; k <= r3 + 39; k++) begin
      waitTo(k);
      if (int'(mix_level) > peak) peak = int'(mix_level);
    end
    check("mix_max", peak, 180);

    // Reserved registers: data would retrigger/mute/reconfigure if mis-decoded
    wrAt(r3 + 40, 2'd3, 2'd3, 8'hFE);
    wrAt(r3 + 41, 2'd0, 2'd3, 8'hFE);
    waitTo(r3 + 48); check("reserved_wave_lo", wave_o, 3'b000);
    waitTo(r3 + 64); check("reserved_wave_hi", wave_o, 3'b111);
    waitTo(r3 + 65); check("reserved_mix", mix_level, 180);
    waitTo(r3 + 66); check("pre_reset_wave", wave_o, 3'b111);

    // Asynchronous reset mid-tone
    #2 rst = 1'b1;
    #1;
    check("async_rst_wave",   wave_o,     0);
    check("async_rst_mix",    mix_level,  0);
    check("async_rst_signal", signal_out, 0);
    check("async_rst_noise",  noise_o,    1);
    @(negedge clk);
    rst = 1'b0;
    quietBad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (signal_out !== 1'b0 || mix_level !== 8'd0 || wave_o !== 3'd0) quietBad++;
    end
    check("post_reset_quiet", quietBad, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
